// File: rtl/min_search_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// min_search_ctrl_pkg
// Shared types and defaults for the codebook minimum-search block.
//   state_t           : sequencer states (also exported for debug visibility)
//   DATA_WIDTH_DEF    : default distance width
//   NUM_CODES_DEF     : default number of distances per frame
//   IDX_WIDTH_DEF     : default codeword index width
//   DIST_MAX          : all-ones distance at the default width
// -----------------------------------------------------------------------------
package min_search_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int NUM_CODES_DEF  = 32;
  localparam int IDX_WIDTH_DEF  = 5;

  localparam logic [DATA_WIDTH_DEF-1:0] DIST_MAX = '1;

endpackage

// File: rtl/min_search_ctrl_if.sv
// -----------------------------------------------------------------------------
// min_search_ctrl_if
// Bundles the control, distance stream and result signals of min_search_ctrl.
//   start, abort            : frame control from the upstream controller
//   distance_data/_en       : distance stream from the distance engine
//   busy                    : high while a frame is in SEARCH or FLUSH
//   min_value/min_index     : result of the last completed frame
//   result_valid            : one-cycle pulse when the result updates
//   fsm_state               : sequencer state, for observation only
//
// Handshake: distance_en is a valid strobe with no ready. A distance is
// consumed on every rising edge where distance_en is high and the block is
// in SEARCH; anywhere else it is dropped. The producer must never rely on
// backpressure.
// Modports: master = stimulus/controller side, slave = min_search_ctrl.
// -----------------------------------------------------------------------------
interface min_search_ctrl_if
  import min_search_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 5
);
  logic                  start;
  logic                  abort;
  logic [DATA_WIDTH-1:0] distance_data;
  logic                  distance_en;
  logic                  busy;
  logic [DATA_WIDTH-1:0] min_value;
  logic [IDX_WIDTH-1:0]  min_index;
  logic                  result_valid;
  state_t                fsm_state;

  modport master (
    output start, abort, distance_data, distance_en,
    input  busy, min_value, min_index, result_valid, fsm_state
  );

  modport slave (
    input  start, abort, distance_data, distance_en,
    output busy, min_value, min_index, result_valid, fsm_state
  );
endinterface

// File: rtl/min_search_ctrl_min_cmp_stage.sv
// -----------------------------------------------------------------------------
// min_cmp_stage
// Registered two-input unsigned minimum with index passthrough, 1-cycle latency.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in1_val/in1_idx     : candidate 1 (fed-back running minimum or seed)
//   in2_val/in2_idx     : candidate 2 (new distance or all-ones filler)
//   out_val/out_idx     : registered winner
// Ties pick in1, so the earlier index survives and an all-ones filler on in2
// never disturbs the running minimum.
// -----------------------------------------------------------------------------
module min_cmp_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in1_val,
  input  logic [IDX_WIDTH-1:0]  in1_idx,
  input  logic [DATA_WIDTH-1:0] in2_val,
  input  logic [IDX_WIDTH-1:0]  in2_idx,
  output logic [DATA_WIDTH-1:0] out_val,
  output logic [IDX_WIDTH-1:0]  out_idx
);
  logic [DATA_WIDTH-1:0] val_d, val_q;
  logic [IDX_WIDTH-1:0]  idx_d, idx_q;

  always_comb begin
    val_d = in2_val;
    idx_d = in2_idx;
    if (in1_val <= in2_val) begin
      val_d = in1_val;
      idx_d = in1_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
      idx_q <= '0;
    end else begin
      val_q <= val_d;
      idx_q <= idx_d;
    end
  end

  assign out_val = val_q;
  assign out_idx = idx_q;
endmodule

// File: rtl/min_search_ctrl.sv
// -----------------------------------------------------------------------------
// min_search_ctrl
// Folds one frame of NUM_CODES unsigned distances into a running minimum and
// reports the global minimum and its 0-based arrival index.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : min_search_ctrl_if.slave (start/abort, distance stream, result,
//            busy, fsm_state)
// Flow: IDLE -start-> SEARCH -last sample-> FLUSH -> DONE (result pulse)
//       -> SEARCH on start, else IDLE. abort forces IDLE from any state.
// The running minimum lives in min_cmp_stage; its output is fed back on
// compare input 1 while new distances enter on input 2.
// -----------------------------------------------------------------------------
module min_search_ctrl
  import min_search_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CODES  = 32,
  parameter int IDX_WIDTH  = $clog2(NUM_CODES)
) (
  input  logic              clk,
  input  logic              rst_n,
  min_search_ctrl_if.slave  bus
);
  localparam logic [DATA_WIDTH-1:0] DIST_ALL_ONES = '1;
  localparam logic [IDX_WIDTH-1:0]  LAST_CNT      = IDX_WIDTH'(NUM_CODES - 1);

  state_t                state_d, state_q;
  logic [IDX_WIDTH-1:0]  cnt_d, cnt_q;
  logic                  first_d, first_q;
  logic                  busy_d, busy_q;
  logic                  result_valid_d, result_valid_q;
  logic [DATA_WIDTH-1:0] min_value_d, min_value_q;
  logic [IDX_WIDTH-1:0]  min_index_d, min_index_q;

  logic [DATA_WIDTH-1:0] in1_val, in2_val, cmp_val;
  logic [IDX_WIDTH-1:0]  in1_idx, in2_idx, cmp_idx;
  logic                  sample_acc;
  logic                  last_sample;

  assign sample_acc  = (state_q == SEARCH) && bus.distance_en;
  assign last_sample = sample_acc && (cnt_q == LAST_CNT);

  // The first accepted sample of a frame is compared against an all-ones seed
  // so whatever the comparator held from before cannot leak into this frame.
  always_comb begin
    in1_val = cmp_val;
    in1_idx = cmp_idx;
    in2_val = DIST_ALL_ONES;
    in2_idx = '0;
    if (sample_acc) begin
      in2_val = bus.distance_data;
      in2_idx = cnt_q;
      if (first_q) begin
        in1_val = DIST_ALL_ONES;
        in1_idx = '0;
      end
    end
  end

  min_cmp_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_cmp (
    .clk     (clk),
    .rst_n   (rst_n),
    .in1_val (in1_val),
    .in1_idx (in1_idx),
    .in2_val (in2_val),
    .in2_idx (in2_idx),
    .out_val (cmp_val),
    .out_idx (cmp_idx)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    first_d        = first_q;
    result_valid_d = 1'b0;
    min_value_d    = min_value_q;
    min_index_d    = min_index_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SEARCH;
          cnt_d   = '0;
          first_d = 1'b1;
        end
      end
      SEARCH: begin
        // start here is deliberately ignored: a frame is never restarted.
        if (sample_acc) begin
          first_d = 1'b0;
          if (last_sample) begin
            state_d = FLUSH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        // Comparator now holds the final winner of the frame.
        state_d        = DONE;
        min_value_d    = cmp_val;
        min_index_d    = cmp_idx;
        result_valid_d = 1'b1;
      end
      DONE: begin
        if (bus.start) begin
          state_d = SEARCH;
          cnt_d   = '0;
          first_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // abort overrides everything, including the FLUSH capture and pulse.
    if (bus.abort) begin
      state_d        = IDLE;
      cnt_d          = '0;
      first_d        = 1'b0;
      result_valid_d = 1'b0;
      min_value_d    = min_value_q;
      min_index_d    = min_index_q;
    end
  end

  assign busy_d = (state_d == SEARCH) || (state_d == FLUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      first_q        <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      min_value_q    <= '0;
      min_index_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      first_q        <= first_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      min_value_q    <= min_value_d;
      min_index_q    <= min_index_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.result_valid = result_valid_q;
  assign bus.min_value    = min_value_q;
  assign bus.min_index    = min_index_q;
  assign bus.fsm_state    = state_q;
endmodule

// File: tb/tb_min_search_ctrl.sv
// -----------------------------------------------------------------------------
// tb_min_search_ctrl
// Directed bench for min_search_ctrl. Instance a uses NUM_CODES=4, instance b
// uses NUM_CODES=32. Inputs change 1 time unit after the rising edge and
// outputs are checked at that same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_min_search_ctrl;
  import min_search_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  min_search_ctrl_if #(.DATA_WIDTH(16), .IDX_WIDTH(2)) if_a ();
  min_search_ctrl_if #(.DATA_WIDTH(16), .IDX_WIDTH(5)) if_b ();

  min_search_ctrl #(.DATA_WIDTH(16), .NUM_CODES(4), .IDX_WIDTH(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  min_search_ctrl #(.DATA_WIDTH(16), .NUM_CODES(32), .IDX_WIDTH(5)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b.slave)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic drive(input int w, input logic st, input logic ab,
                       input logic en, input logic [15:0] d);
    if (w == 0) begin
      if_a.start = st; if_a.abort = ab; if_a.distance_en = en; if_a.distance_data = d;
    end else begin
      if_b.start = st; if_b.abort = ab; if_b.distance_en = en; if_b.distance_data = d;
    end
  endtask

  function automatic logic [31:0] o_rv(input int w);
    return (w == 0) ? 32'(if_a.result_valid) : 32'(if_b.result_valid);
  endfunction
  function automatic logic [31:0] o_busy(input int w);
    return (w == 0) ? 32'(if_a.busy) : 32'(if_b.busy);
  endfunction
  function automatic logic [31:0] o_mv(input int w);
    return (w == 0) ? 32'(if_a.min_value) : 32'(if_b.min_value);
  endfunction
  function automatic logic [31:0] o_mi(input int w);
    return (w == 0) ? 32'(if_a.min_index) : 32'(if_b.min_index);
  endfunction
  function automatic logic [31:0] o_st(input int w);
    return (w == 0) ? 32'(if_a.fsm_state) : 32'(if_b.fsm_state);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start cycle also presents a distance of 0 with distance_en high; it must
  // be ignored, otherwise it would become the frame minimum.
  task automatic begin_frame(input int w);
    drive(w, 1'b1, 1'b0, 1'b1, 16'h0000);
    tick();
  endtask

  // Feeds one frame starting in the first sample cycle, then checks FLUSH,
  // the DONE pulse and the cycle after it. With gaps, start is pulsed in the
  // first idle cycle after each sample and must be ignored while busy.
  // With chain set, start (plus an ignored distance) is issued in DONE.
  task automatic feed(input int w, input logic [15:0] vals[$], input bit gaps,
                      input logic [31:0] ev, input logic [31:0] ei,
                      input logic [31:0] pv, input logic [31:0] pi,
                      input bit chain, input string tag);
    for (int i = 0; i < vals.size(); i++) begin
      drive(w, 1'b0, 1'b0, 1'b1, vals[i]);
      chk({tag, "_busy"}, o_busy(w), 32'd1);
      chk({tag, "_rv_lo"}, o_rv(w), 32'd0);
      chk({tag, "_hold_v"}, o_mv(w), pv);
      chk({tag, "_hold_i"}, o_mi(w), pi);
      tick();
      if (gaps && (i != vals.size() - 1)) begin
        for (int g = 0; g <= (i % 3); g++) begin
          drive(w, (g == 0), 1'b0, 1'b0, 16'h0000);
          chk({tag, "_gap_busy"}, o_busy(w), 32'd1);
          chk({tag, "_gap_rv"}, o_rv(w), 32'd0);
          tick();
        end
      end
    end
    drive(w, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk({tag, "_flush_busy"}, o_busy(w), 32'd1);
    chk({tag, "_flush_rv"}, o_rv(w), 32'd0);
    chk({tag, "_flush_st"}, o_st(w), 32'(FLUSH));
    tick();
    chk({tag, "_done_rv"}, o_rv(w), 32'd1);
    chk({tag, "_done_v"}, o_mv(w), ev);
    chk({tag, "_done_i"}, o_mi(w), ei);
    chk({tag, "_done_busy"}, o_busy(w), 32'd0);
    if (chain) drive(w, 1'b1, 1'b0, 1'b1, 16'h0000);
    else       drive(w, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    chk({tag, "_post_rv"}, o_rv(w), 32'd0);
    chk({tag, "_post_busy"}, o_busy(w), 32'(chain));
    chk({tag, "_post_v"}, o_mv(w), ev);
  endtask

  logic [15:0] q[$];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 16'h0);
    tick();

    // reset state
    chk("rst_busy_a", o_busy(0), 32'd0);
    chk("rst_rv_a", o_rv(0), 32'd0);
    chk("rst_mv_a", o_mv(0), 32'd0);
    chk("rst_mi_a", o_mi(0), 32'd0);
    chk("rst_st_a", o_st(0), 32'(IDLE));
    chk("rst_mv_b", o_mv(1), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    tick();

    // 1: back-to-back 9,3,7,5 -> 3 @ 1
    begin_frame(0);
    q = {16'd9, 16'd3, 16'd7, 16'd5};
    feed(0, q, 1'b0, 32'd3, 32'd1, 32'd0, 32'd0, 1'b0, "t1");

    // 2: same data with gaps, start pulses while busy ignored
    begin_frame(0);
    feed(0, q, 1'b1, 32'd3, 32'd1, 32'd3, 32'd1, 1'b0, "t2");

    // 3: ties and all-ones frame
    begin_frame(0);
    q = {16'd6, 16'd2, 16'd2, 16'd8};
    feed(0, q, 1'b0, 32'd2, 32'd1, 32'd3, 32'd1, 1'b0, "t3a");
    begin_frame(0);
    q = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    feed(0, q, 1'b0, 32'hFFFF, 32'd0, 32'd2, 32'd1, 1'b0, "t3b");

    // 4: abort (together with start) after 2 samples, then a fresh frame
    begin_frame(0);
    drive(0, 1'b0, 1'b0, 1'b1, 16'd10);
    tick();
    drive(0, 1'b0, 1'b0, 1'b1, 16'd0);
    tick();
    drive(0, 1'b1, 1'b1, 1'b1, 16'd0);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 16'd0);
    chk("t4_abort_busy", o_busy(0), 32'd0);
    chk("t4_abort_st", o_st(0), 32'(IDLE));
    chk("t4_abort_rv", o_rv(0), 32'd0);
    tick();
    tick();
    chk("t4_idle_rv", o_rv(0), 32'd0);
    chk("t4_idle_v", o_mv(0), 32'hFFFF);
    begin_frame(0);
    q = {16'd4, 16'd4, 16'd1, 16'd4};
    feed(0, q, 1'b0, 32'd1, 32'd2, 32'hFFFF, 32'd0, 1'b0, "t4");

    // abort in FLUSH: no pulse, previous result held
    begin_frame(0);
    q = {16'd0, 16'd5, 16'd5, 16'd5};
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b0, 1'b0, 1'b1, q[i]);
      tick();
    end
    drive(0, 1'b0, 1'b1, 1'b0, 16'd0);
    chk("t4f_flush_st", o_st(0), 32'(FLUSH));
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 16'd0);
    chk("t4f_rv", o_rv(0), 32'd0);
    chk("t4f_busy", o_busy(0), 32'd0);
    tick();
    chk("t4f_rv2", o_rv(0), 32'd0);
    chk("t4f_v", o_mv(0), 32'd1);
    chk("t4f_i", o_mi(0), 32'd2);

    // 5: two 32-sample frames back to back, start in DONE, min at index 31
    begin_frame(1);
    q = {};
    for (int i = 0; i < 32; i++) q.push_back(16'(1000 - 10 * i));
    feed(1, q, 1'b0, 32'd690, 32'd31, 32'd0, 32'd0, 1'b1, "t5a");
    q = {};
    for (int i = 0; i < 32; i++) q.push_back(16'(500 - i));
    feed(1, q, 1'b0, 32'd469, 32'd31, 32'd690, 32'd31, 1'b0, "t5b");

    // 6: asynchronous reset mid-SEARCH, then a clean frame
    begin_frame(0);
    drive(0, 1'b0, 1'b0, 1'b1, 16'd1);
    tick();
    drive(0, 1'b0, 1'b0, 1'b1, 16'd1);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 16'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", o_busy(0), 32'd0);
    chk("t6_rv", o_rv(0), 32'd0);
    chk("t6_mv", o_mv(0), 32'd0);
    chk("t6_mi", o_mi(0), 32'd0);
    chk("t6_st", o_st(0), 32'(IDLE));
    chk("t6_mv_b", o_mv(1), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    begin_frame(0);
    q = {16'd50, 16'd40, 16'd60, 16'd45};
    feed(0, q, 1'b0, 32'd40, 32'd1, 32'd0, 32'd0, 1'b0, "t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
